// File: rtl/trisc_pkg.sv
// Shared definitions for the trisc controller and its condition front end.
// Holds the condition-line count, the clear-select encoding and the location
// of the clear fields inside the controller's out_sig control word.
package trisc_pkg;

  localparam int NCS = 3;
  localparam int CW  = (1 << NCS) - 1;

  // clr_sel value that targets every condition line at once.
  localparam logic [NCS-1:0] CLR_ALL = '0;

  // Placement of the clear strobe and clear-select field inside out_sig.
  localparam int OUT_SIG_W   = 16;
  localparam int CLR_EN_BIT  = 12;
  localparam int CLR_SEL_LSB = 13;

  function automatic logic out_sig_clr_en(input logic [OUT_SIG_W-1:0] out_sig);
    return out_sig[CLR_EN_BIT];
  endfunction

  function automatic logic [NCS-1:0] out_sig_clr_sel(input logic [OUT_SIG_W-1:0] out_sig);
    return out_sig[CLR_SEL_LSB +: NCS];
  endfunction

  // One clear bit per line: CLR_ALL hits every line, k hits line k-1.
  function automatic logic [CW-1:0] clr_decode(input logic en, input logic [NCS-1:0] sel);
    logic [CW-1:0] hit;
    for (int i = 0; i < CW; i++) begin
      hit[i] = en && ((sel == CLR_ALL) || (sel == NCS'(i + 1)));
    end
    return hit;
  endfunction

endpackage

// File: rtl/trisc_cond_unit_if.sv
// Bundle between the controller side and the condition front end: raw flags,
// the sticky mask and the clear field going in, cond and ovf coming back.
interface trisc_cond_unit_if;
  import trisc_pkg::*;

  logic [CW-1:0]  raw_in;
  logic [CW-1:0]  sticky_mask;
  logic           clr_en;
  logic [NCS-1:0] clr_sel;
  logic [CW-1:0]  cond;
  logic [CW-1:0]  ovf;

  modport master (
    output raw_in, sticky_mask, clr_en, clr_sel,
    input  cond, ovf
  );

  modport slave (
    input  raw_in, sticky_mask, clr_en, clr_sel,
    output cond, ovf
  );

endinterface

// File: rtl/trisc_cond_line.sv
// One condition line: synchroniser, optional debounce, sticky flag, overrun.
// Build option TRISC_COND_DEBOUNCE_EN: when defined, a new synchronised level
// must persist DB_CYCLES edges before db_q follows it; when undefined, db_q
// follows the synchroniser every edge and DB_CYCLES has no effect.
module trisc_cond_line #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clr,
  output logic db_q,
  output logic stk,
  output logic ovf
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   rise;

  assign sync_out = sync[SYNC_STAGES-1];

  // Shift the asynchronous flag through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

`ifdef TRISC_COND_DEBOUNCE_EN
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;

  // A 0->1 acceptance on this edge is the line's rise event.
  assign rise = sync_out && !db_q && (db_cnt == DB_LAST);

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else if (sync_out == db_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_q   <= sync_out;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end
`else
  localparam int unused_db_cycles = DB_CYCLES;

  assign rise = sync_out && !db_q;

  // Without debounce the synchronised level is accepted on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= 1'b0;
    end else begin
      db_q <= sync_out;
    end
  end
`endif

  // Sticky flag and overrun: a rise always wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stk <= 1'b0;
      ovf <= 1'b0;
    end else begin
      stk <= rise | (stk & ~clr);
      ovf <= (rise & stk & ~clr) | (ovf & ~clr);
    end
  end

endmodule

// File: rtl/trisc_cond_unit.sv
// Condition-input front end feeding the trisc cond bus. Each raw flag is
// synchronised, debounced and presented as a level or a sticky condition
// selected by sticky_mask; sticky lines are cleared by the clear field of
// the controller's out_sig. Build option TRISC_COND_DEBOUNCE_EN enables the
// DB_CYCLES debounce filter in every line.
module trisc_cond_unit
  import trisc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               reset,
  trisc_cond_unit_if.slave   bus
);

  logic [CW-1:0] clr_hit;
  logic [CW-1:0] db_q;
  logic [CW-1:0] stk;
  logic [CW-1:0] ovf_line;

  // Turn the clear strobe and select field into one clear bit per line.
  always_comb begin
    clr_hit = clr_decode(bus.clr_en, bus.clr_sel);
  end

  for (genvar i = 0; i < CW; i++) begin : g_line
    trisc_cond_line #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_line (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_in[i]),
      .clr   (clr_hit[i]),
      .db_q  (db_q[i]),
      .stk   (stk[i]),
      .ovf   (ovf_line[i])
    );
  end

  // Pick sticky or level per line; overrun only means something on sticky lines.
  always_comb begin
    bus.cond = (bus.sticky_mask & stk) | (~bus.sticky_mask & db_q);
    bus.ovf  = bus.sticky_mask & ovf_line;
  end

endmodule
